// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared constants for the push-button input peripheral:
//               IO register offsets and the default debounce length.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // IO-window offsets decoded by button_driver
    localparam logic [11:0] BTN_LEVEL_ADDR = 12'h078;
    localparam logic [11:0] BTN_PEND_ADDR  = 12'h07C;
    localparam logic [11:0] BTN_CNT_ADDR   = 12'h080;

    // Stable cycles required before a new button level is accepted
    localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;

endpackage : button_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Single-bit button conditioner. A two-flop synchroniser feeds
//               a counter that must observe DEBOUNCE_CYCLES consecutive
//               mismatching samples before the stable level follows.
// Ports       : clk       - system clock
//               rst_n     - synchronous reset, active-low
//               btn_async - raw button level, 1 = pressed
//               stable    - debounced level
//               rise      - one-cycle pulse on the edge stable goes 0->1
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_async,
    output logic stable,
    output logic rise
);

    // The counter never exceeds DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_mismatch;
    logic w_accept;

    assign w_mismatch = (r_sync2 != r_stable);
    // Final mismatching sample: the level has held long enough to adopt.
    assign w_accept   = w_mismatch && (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= btn_async;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                // Any agreeing sample (including the end of a glitch) restarts the count.
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    // Asserted in the same cycle the press is being accepted, so the
    // pending/count logic updates on the same edge as stable.
    assign rise   = w_accept && r_sync2;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_driver.sv
`default_nettype none
// ============================================================================
// Module      : button_driver
// Description : Memory-mapped push-button peripheral. Debounces NUM_BTN
//               buttons, latches press events (W1C pending bits), counts
//               presses and serves them on the IO read path.
// Ports       : clk     - system clock
//               rst_n   - synchronous reset, active-low
//               btn     - raw button levels, 1 = pressed
//               IOen    - IO-region select
//               IOwe    - store strobe (qualified by IOen)
//               IOaddr  - IO offset
//               IOwdata - store data
//               IOrdata - combinational read data
//               btn_irq - registered OR of pending bits
// Revision    : 1.0 - initial release
// ============================================================================
module button_driver
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               IOen,
    input  logic               IOwe,
    input  logic [11:0]        IOaddr,
    input  logic [31:0]        IOwdata,
    output logic [31:0]        IOrdata,
    output logic               btn_irq
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_pend_clr;
    logic [CNT_W-1:0]   w_rise_cnt;
    logic               w_wr;
    logic               w_cnt_clr;
    logic               w_unused_wdata;

    logic [NUM_BTN-1:0] r_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_irq;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .rst_n    (rst_n),
                .btn_async(btn[gi]),
                .stable   (w_level[gi]),
                .rise     (w_rise[gi])
            );
        end
    endgenerate

    // Write decode
    assign w_wr       = IOen && IOwe;
    assign w_pend_clr = (w_wr && (IOaddr == BTN_PEND_ADDR)) ? IOwdata[NUM_BTN-1:0] : '0;
    assign w_cnt_clr  = w_wr && (IOaddr == BTN_CNT_ADDR);

    // Only the low NUM_BTN store bits carry meaning.
    assign w_unused_wdata = ^IOwdata;

    // Number of buttons newly pressed this cycle (wraps with the counter).
    always_comb begin
        w_rise_cnt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_rise_cnt = w_rise_cnt + CNT_W'(w_rise[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
            r_irq  <= 1'b0;
        end else begin
            // New presses are OR-ed in after the clear, so a coincident set wins.
            r_pend <= (r_pend & ~w_pend_clr) | w_rise;
            // A clear still credits presses arriving on the same edge.
            r_cnt  <= (w_cnt_clr ? '0 : r_cnt) + w_rise_cnt;
            r_irq  <= |r_pend;
        end
    end

    // Single-cycle read path; store cycles and unmapped offsets return zero.
    always_comb begin
        IOrdata = '0;
        if (rst_n && IOen && !IOwe) begin
            case (IOaddr)
                BTN_LEVEL_ADDR: IOrdata = 32'(w_level);
                BTN_PEND_ADDR:  IOrdata = 32'(r_pend);
                BTN_CNT_ADDR:   IOrdata = 32'(r_cnt);
                default:        IOrdata = '0;
            endcase
        end
    end

    assign btn_irq = r_irq;

endmodule : button_driver
`default_nettype wire
